// File: rtl/frame_encoder.sv
// frame_encoder: serializes start/end angle plus NUM_POINTS Q16.16 (x, y) points into
// a framed byte stream (sync, LEN, LE payload, CHK). Define FRAME_ENCODER_CRC8_EN for CRC-8 CHK.
module frame_encoder #(
  parameter int unsigned NUM_POINTS = 12,
  parameter logic [7:0]  SYNC0      = 8'hAA,
  parameter logic [7:0]  SYNC1      = 8'h55
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        start_angle10_in,
  input  logic [15:0]        end_angle10_in,
  input  logic signed [31:0] points_x_q16_16 [0:NUM_POINTS-1],
  input  logic signed [31:0] points_y_q16_16 [0:NUM_POINTS-1],
  input  logic               points_valid,
  output logic               points_ready,
  output logic [7:0]         dout,
  output logic               wr_en,
  input  logic               fifo_out_full,
  output logic               busy
);

  localparam int unsigned LEN   = 4 + 8 * NUM_POINTS;
  localparam int unsigned KW    = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;
  localparam logic [7:0]  LEN_B = 8'(LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC0, S_SYNC1, S_LEN, S_PAY, S_CHK
  } state_t;

  state_t             r_state;
  logic [7:0]         r_idx;
  logic [7:0]         r_acc;
  logic [15:0]        r_sa;
  logic [15:0]        r_ea;
  logic signed [31:0] r_x [0:NUM_POINTS-1];
  logic signed [31:0] r_y [0:NUM_POINTS-1];

  logic [7:0]    w_sel_idx;
  logic [7:0]    w_p;
  logic [KW-1:0] w_k;
  logic [31:0]   w_word;
  logic [15:0]   w_ang;
  logic [7:0]    w_next_byte;
  logic [7:0]    w_acc_upd;

  // Checksum step over one written byte.
  function automatic logic [7:0] acc_upd(input logic [7:0] acc, input logic [7:0] b);
    logic [7:0] c;
`ifdef FRAME_ENCODER_CRC8_EN
    c = acc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
`else
    c = acc + b;
`endif
    return c;
  endfunction

  // dout always holds the byte to be written next; this picks the payload byte after it.
  always_comb begin
    w_sel_idx = (r_state == S_LEN) ? 8'd0 : r_idx + 8'd1;
    w_p       = w_sel_idx - 8'd4;
    w_k       = KW'(w_p[7:3]);
    w_word    = w_p[2] ? r_y[w_k] : r_x[w_k];
    w_ang     = w_sel_idx[1] ? r_ea : r_sa;
    if (w_sel_idx < 8'd4) begin
      w_next_byte = w_sel_idx[0] ? w_ang[15:8] : w_ang[7:0];
    end else begin
      w_next_byte = w_word[{w_p[1:0], 3'b000} +: 8];
    end
    w_acc_upd = acc_upd(r_acc, dout);
  end

  assign wr_en = (r_state != S_IDLE) && !fifo_out_full && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= 8'd0;
      r_acc        <= 8'd0;
      dout         <= 8'd0;
      points_ready <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (points_valid && points_ready) begin
            r_sa         <= start_angle10_in;
            r_ea         <= end_angle10_in;
            r_x          <= points_x_q16_16;
            r_y          <= points_y_q16_16;
            r_idx        <= 8'd0;
            r_acc        <= 8'd0;
            dout         <= SYNC0;
            points_ready <= 1'b0;
            busy         <= 1'b1;
            r_state      <= S_SYNC0;
          end else begin
            points_ready <= 1'b1;
          end
        end
        S_SYNC0: if (wr_en) begin
          dout    <= SYNC1;
          r_state <= S_SYNC1;
        end
        S_SYNC1: if (wr_en) begin
          dout    <= LEN_B;
          r_state <= S_LEN;
        end
        S_LEN: if (wr_en) begin
          r_acc   <= w_acc_upd;
          r_idx   <= 8'd0;
          dout    <= w_next_byte;
          r_state <= S_PAY;
        end
        S_PAY: if (wr_en) begin
          r_acc <= w_acc_upd;
          if (r_idx == LEN_B - 8'd1) begin
            dout    <= w_acc_upd;
            r_state <= S_CHK;
          end else begin
            dout  <= w_next_byte;
            r_idx <= r_idx + 8'd1;
          end
        end
        S_CHK: if (wr_en) begin
          dout         <= 8'd0;
          points_ready <= 1'b1;
          busy         <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
